// File: rtl/hsv_core_decode_iq.sv
// Multi-lane fetch-to-decode instruction queue.
// Up to LANES packets are accepted per cycle, compacted in lane order and
// presented one per cycle to decode. flush_req empties the queue at the next
// edge, and flush_ack echoes flush_req one cycle later.
// Optional: define HSV_DECODE_IQ_STATS_EN to add the hwm and stall_cycles
// statistics outputs.
module hsv_core_decode_iq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                     clk_core,
  input  logic                     rst_core_n,
  input  logic                     flush_req,
  output logic                     flush_ack,
  output logic                     ready_o,
  input  logic [LANES-1:0]         valid_i,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef HSV_DECODE_IQ_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   hwm,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] LanesCnt = CntW'(LANES);

  // Reject unsupported configurations at elaboration
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < LANES) begin : g_bad_depth
    $error("hsv_core_decode_iq: DEPTH must be a power of two, >= 2 and >= LANES");
  end
  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("hsv_core_decode_iq: LANES must be in 1..4");
  end

  // Storage is deliberately left without reset
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            flush_ack_q;

  logic            push_fire;
  logic            pop_fire;
  logic [CntW-1:0] free_slots;
  logic [CntW-1:0] n_valid;
  logic [CntW-1:0] n_push;
  logic [LANES-1:0] wr_en;
  logic [PtrW-1:0] wr_addr [LANES];

  // Handshake outputs depend only on registered occupancy and flush_req
  assign free_slots = DepthCnt - count_q;
  assign ready_o    = ~flush_req & (free_slots >= LanesCnt);
  assign valid_o    = (count_q != '0) & ~flush_req;
  assign push_fire  = ready_o & (|valid_i);
  assign pop_fire   = valid_o & ready_i;
  assign n_push     = push_fire ? n_valid : '0;

  assign out_data  = mem_q[head_q];
  assign count     = count_q;
  assign flush_ack = flush_ack_q;

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it
  always_comb begin
    n_valid = '0;
    wr_en   = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_addr[k] = tail_q + n_valid[PtrW-1:0];
      wr_en[k]   = push_fire & valid_i[k];
      n_valid    = n_valid + CntW'(valid_i[k]);
    end
  end

  // Pointer and occupancy next state; flush overrides any push or pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_req) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PtrW'(pop_fire);
      tail_d  = tail_q + n_push[PtrW-1:0];
      count_d = count_q + n_push - CntW'(pop_fire);
    end
  end

  // Control state register
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      flush_ack_q <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      flush_ack_q <= flush_req;
    end
  end

  // Entry storage writes; lanes of one group always target distinct slots
  always_ff @(posedge clk_core) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) begin
        mem_q[wr_addr[k]] <= in_data[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef HSV_DECODE_IQ_STATS_EN
  logic [CntW-1:0] hwm_q;
  logic [31:0]     stall_q;
  logic            stall_evt;

  // Fetch offering a group that the queue cannot take (flush cycles excluded)
  assign stall_evt = (|valid_i) & ~ready_o & ~flush_req;

  // High-water mark tracks next occupancy; stall counter saturates
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      hwm_q   <= '0;
      stall_q <= '0;
    end else begin
      if (count_d > hwm_q) begin
        hwm_q <= count_d;
      end
      if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign hwm          = hwm_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_hsv_core_decode_iq.sv
// Bench for hsv_core_decode_iq at DEPTH=8, LANES=2, WIDTH=64.
// A queue-based scoreboard predicts handshakes, occupancy and head data; a
// vector table adds hand-derived ready/valid/count/flush_ack expectations.
module tb_hsv_core_decode_iq;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LANES = 2;

  logic                   clk_core = 1'b0;
  logic                   rst_core_n;
  logic                   flush_req;
  logic                   flush_ack;
  logic                   ready_o;
  logic [LANES-1:0]       valid_i;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   ready_i;
  logic                   valid_o;
  logic [WIDTH-1:0]       out_data;
  logic [3:0]             count;
`ifdef HSV_DECODE_IQ_STATS_EN
  logic [3:0]             hwm;
  logic [31:0]            stall_cycles;
`endif

  always #5 clk_core = ~clk_core;

  hsv_core_decode_iq #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .LANES(LANES)
  ) dut (
    .clk_core    (clk_core),
    .rst_core_n  (rst_core_n),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .ready_o     (ready_o),
    .valid_i     (valid_i),
    .in_data     (in_data),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .out_data    (out_data),
    .count       (count)
`ifdef HSV_DECODE_IQ_STATS_EN
    ,
    .hwm         (hwm),
    .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic       fl;
    logic [1:0] v;
    logic       rdy;
    logic       e_ready;
    logic       e_valid;
    int         e_cnt;
    logic       e_fack;
  } vec_t;

  localparam int NVec = 41;
  vec_t tbl [NVec];

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard / model state
  logic [WIDTH-1:0] exp_q [$];
  logic             m_fack;
  int               m_hwm;
  int unsigned      m_stall;
  logic             cur_fl;
  logic [1:0]       cur_v;
  logic             cur_rdy;
  logic             m_ready;
  logic             m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle's inputs (called just after a falling edge) and check outputs
  task automatic apply(input logic fl, input logic [1:0] v, input logic rdy);
    flush_req = fl;
    valid_i   = v;
    ready_i   = rdy;
    in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
    cur_fl    = fl;
    cur_v     = v;
    cur_rdy   = rdy;
    #2;
    m_ready = !fl && ((int'(DEPTH) - exp_q.size()) >= int'(LANES));
    m_valid = !fl && (exp_q.size() != 0);
    chk("ready_o", 64'(ready_o), 64'(m_ready));
    chk("valid_o", 64'(valid_o), 64'(m_valid));
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("flush_ack", 64'(flush_ack), 64'(m_fack));
    if (m_valid) chk("out_data", out_data, exp_q[0]);
`ifdef HSV_DECODE_IQ_STATS_EN
    chk("hwm", 64'(hwm), 64'(m_hwm));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
  endtask

  // Clock edge, then update the model with what the edge should have done
  task automatic advance();
    @(posedge clk_core);
    if (cur_fl) begin
      exp_q.delete();
    end else begin
      if (m_valid && cur_rdy) void'(exp_q.pop_front());
      if (m_ready) begin
        for (int k = 0; k < int'(LANES); k++) begin
          if (cur_v[k]) exp_q.push_back(in_data[k*WIDTH +: WIDTH]);
        end
      end
    end
    if ((cur_v != 2'b00) && !m_ready && !cur_fl && (m_stall != 32'hFFFF_FFFF)) m_stall++;
    if (exp_q.size() > m_hwm) m_hwm = exp_q.size();
    m_fack = cur_fl;
    @(negedge clk_core);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_core_n = 1'b0;
    flush_req  = 1'b0;
    valid_i    = '0;
    ready_i    = 1'b0;
    in_data    = '0;
    m_fack     = 1'b1;
    m_hwm      = 0;
    m_stall    = 0;

    // fl, valid, rdy -> ready_o, valid_o, count, flush_ack (before the edge)
    tbl[0]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b1};  // out of reset
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[2]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0, 1'b0};  // fill A0..A7
    tbl[3]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 2, 1'b0};
    tbl[4]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 4, 1'b0};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b1, 6, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8, 1'b0};  // full
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 8, 1'b0};  // offered while full: ignored
    tbl[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8, 1'b0};  // drain
    tbl[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 7, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 6, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 5, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 4, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 3, 1'b0};
    tbl[14] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1'b0};
    tbl[15] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    tbl[16] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[17] = '{1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 0, 1'b0};  // B1 only
    tbl[18] = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1, 1'b0};  // C0 only
    tbl[19] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 1, 1'b0};  // D0, D1
    tbl[20] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1'b0};
    tbl[21] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1, 1'b0};
    tbl[22] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[23] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0, 1'b0};  // build tail=7, count=3
    tbl[24] = '{1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 2, 1'b0};
    tbl[25] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 3, 1'b0};  // writes slots 7 and 0
    tbl[26] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 4, 1'b0};
    tbl[27] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 5, 1'b0};
    tbl[28] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 6, 1'b0};
    tbl[29] = '{1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 7, 1'b0};  // ready_o low at 7
    tbl[30] = '{1'b0, 2'b11, 1'b1, 1'b1, 1'b1, 6, 1'b0};
    tbl[31] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 7, 1'b0};
    tbl[32] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 6, 1'b0};
    tbl[33] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 5, 1'b0};  // flush at count=5
    tbl[34] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[35] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[36] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1'b0};
    tbl[37] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 1, 1'b0};  // two-cycle flush
    tbl[38] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 0, 1'b1};
    tbl[39] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[40] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0};

    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
    rst_core_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      apply(tbl[i].fl, tbl[i].v, tbl[i].rdy);
      chk($sformatf("tbl[%0d].ready_o", i), 64'(ready_o), 64'(tbl[i].e_ready));
      chk($sformatf("tbl[%0d].valid_o", i), 64'(valid_o), 64'(tbl[i].e_valid));
      chk($sformatf("tbl[%0d].count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl[%0d].flush_ack", i), 64'(flush_ack), 64'(tbl[i].e_fack));
      advance();
    end

    // Reset mid-operation: contents dropped without waiting for a clock
    apply(1'b0, 2'b11, 1'b0);
    advance();
    flush_req = 1'b0;
    valid_i   = '0;
    ready_i   = 1'b0;
    #1;
    chk("pre_reset_valid_o", 64'(valid_o), 64'd1);
    rst_core_n = 1'b0;
    #1;
    chk("async_reset_valid_o", 64'(valid_o), 64'd0);
    chk("async_reset_count", 64'(count), 64'd0);
    chk("async_reset_flush_ack", 64'(flush_ack), 64'd1);
    chk("async_reset_ready_o", 64'(ready_o), 64'd1);
    exp_q.delete();
    m_fack  = 1'b1;
    m_hwm   = 0;
    m_stall = 0;
    @(posedge clk_core);
    @(negedge clk_core);
    rst_core_n = 1'b1;

    // Fill, hold a full group for 10 stalled cycles, then flush
    repeat (4) begin
      apply(1'b0, 2'b11, 1'b0);
      advance();
    end
    repeat (10) begin
      apply(1'b0, 2'b11, 1'b0);
      advance();
    end
    apply(1'b1, 2'b00, 1'b0);
    advance();
    apply(1'b0, 2'b00, 1'b0);
    chk("post_flush_count", 64'(count), 64'd0);
`ifdef HSV_DECODE_IQ_STATS_EN
    chk("hwm_after_flush", 64'(hwm), 64'd8);
    chk("stall_cycles_total", 64'(stall_cycles), 64'd10);
`endif
    advance();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
